// File: rtl/sld_hub_csr_pkg.sv
// sld_hub_csr_pkg: shared CSR addresses, STATUS bit positions and handover state type
package sld_hub_csr_pkg;
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd2;
  localparam logic [2:0] ADDR_SWCOUNT = 3'd3;
  localparam logic [2:0] ADDR_ERRCLR  = 3'd4;
  localparam int STAT_STICKY = 30;
  localparam int STAT_BUSY   = 31;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT} sld_sw_state_t;
endpackage

// File: rtl/sld_hub_handover_fsm.sv
// sld_hub_handover_fsm: waits for affected channels to be quiet for holdoff cycles, then commits req to the enables
module sld_hub_handover_fsm
  import sld_hub_csr_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLD_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              ctrl_wr,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [NUM_CH-1:0] jtag_idle,
  output logic [NUM_CH-1:0] enable_user_jtag_io,
  output logic              busy,
  output logic              commit,
  output logic              to_flag
);
  localparam logic [HOLD_W-1:0] TO_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);
  sld_sw_state_t     state;
  logic [HOLD_W-1:0] hold_cnt, to_cnt;
  logic [NUM_CH-1:0] diff;
  logic [HOLD_W:0]   hold_nxt;
  logic              quiet;
  assign diff     = req ^ enable_user_jtag_io;
  assign quiet    = &(jtag_idle | ~diff);
  assign hold_nxt = {1'b0, hold_cnt} + (HOLD_W+1)'(1);
  assign busy     = state != ST_IDLE;
  assign commit   = state == ST_COMMIT;
  // >= rather than == so holdoff 0, or a holdoff shrunk mid-wait, still commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      hold_cnt            <= '0;
      to_cnt              <= '0;
      enable_user_jtag_io <= '0;
      to_flag             <= 1'b0;
    end else begin
      to_flag <= 1'b0;
      case (state)
        ST_IDLE: if (|diff) begin
          state    <= ST_WAIT;
          hold_cnt <= '0;
          to_cnt   <= '0;
        end
        ST_WAIT: if (!(|diff)) state <= ST_IDLE;
        else begin
          to_cnt <= to_cnt + HOLD_W'(1);
          if (to_cnt == TO_LAST) begin
            state   <= ST_COMMIT;
            to_flag <= 1'b1;
          end else if (ctrl_wr) hold_cnt <= '0;
          else if (quiet) begin
            if (hold_nxt >= {1'b0, holdoff}) state <= ST_COMMIT;
            else hold_cnt <= hold_nxt[HOLD_W-1:0];
          end else hold_cnt <= '0;
        end
        default: begin
          enable_user_jtag_io <= req;
          state               <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/sld_hub_csr_bank.sv
// sld_hub_csr_bank: Avalon-MM CSR bank driving per-channel user-JTAG-I/O ownership with glitch-safe handover
module sld_hub_csr_bank
  import sld_hub_csr_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int HOLD_W          = 16,
  parameter int HOLDOFF_DEFAULT = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [2:0]        csr_addr,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              csr_readdatavalid,
  input  logic [NUM_CH-1:0] jtag_idle,
  output logic [NUM_CH-1:0] enable_user_jtag_io,
  output logic              switch_busy
);
  logic [NUM_CH-1:0] req;
  logic [HOLD_W-1:0] holdoff;
  logic [CNT_W-1:0]  count;
  logic              sticky, commit, to_flag;
  logic              wr_ctrl, wr_hold, wr_cnt, err_clr;
  logic [31:0]       status, rd_word;
  logic              unused_wd;
  assign unused_wd = ^csr_writedata;
  assign wr_ctrl = csr_write && csr_addr == ADDR_CTRL;
  assign wr_hold = csr_write && csr_addr == ADDR_HOLDOFF;
  assign wr_cnt  = csr_write && csr_addr == ADDR_SWCOUNT;
  assign err_clr = csr_write && csr_addr == ADDR_ERRCLR && csr_writedata[0];
  sld_hub_handover_fsm #(
    .NUM_CH(NUM_CH), .HOLD_W(HOLD_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk(clk), .reset(reset), .req(req), .ctrl_wr(wr_ctrl), .holdoff(holdoff),
    .jtag_idle(jtag_idle), .enable_user_jtag_io(enable_user_jtag_io),
    .busy(switch_busy), .commit(commit), .to_flag(to_flag)
  );
  always_comb begin
    status                = '0;
    status[NUM_CH-1:0]    = enable_user_jtag_io;
    status[STAT_STICKY]   = sticky;
    status[STAT_BUSY]     = switch_busy;
    case (csr_addr)
      ADDR_CTRL:    rd_word = 32'(req);
      ADDR_STATUS:  rd_word = status;
      ADDR_HOLDOFF: rd_word = 32'(holdoff);
      ADDR_SWCOUNT: rd_word = 32'(count);
      default:      rd_word = '0;
    endcase
  end
  // set beats clear for the sticky flag; clear beats increment for the counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req               <= '0;
      holdoff           <= HOLD_W'(HOLDOFF_DEFAULT);
      count             <= '0;
      sticky            <= 1'b0;
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      if (wr_ctrl) req <= csr_writedata[NUM_CH-1:0];
      if (wr_hold) holdoff <= csr_writedata[HOLD_W-1:0];
      if (wr_cnt) count <= '0;
      else if (commit && !(&count)) count <= count + CNT_W'(1);
      sticky            <= to_flag | (sticky & ~err_clr);
      csr_readdatavalid <= csr_read;
      csr_readdata      <= csr_read ? rd_word : '0;
    end
  end
endmodule
